// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator race counter.
package ro_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TMO_W       = 16;

  // Index width for n channels; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ro_race_counter_if.sv
// Control/result bundle between the response logic and the race counter.
interface ro_race_counter_if
  import ro_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TMO_W  = DEF_TMO_W
) ();

  localparam int IDX_W = idx_w(NUM_CH);

  logic                    start;
  logic [CNT_W-1:0]        threshold;
  logic [TMO_W-1:0]        timeout;
  logic [NUM_CH-1:0]       ro_in;
  logic                    busy;
  logic                    done;
  logic                    result_valid;
  logic [IDX_W-1:0]        winner;
  logic                    tie;
  logic                    timed_out;
  logic [NUM_CH*CNT_W-1:0] counts;

  modport master (
    output start, threshold, timeout, ro_in,
    input  busy, done, result_valid, winner, tie, timed_out, counts
  );

  modport slave (
    input  start, threshold, timeout, ro_in,
    output busy, done, result_valid, winner, tie, timed_out, counts
  );

endinterface

// File: rtl/ro_edge_sync.sv
// Per-channel synchroniser and rising-edge detector for one RO output.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  input  logic load_i,
  input  logic track_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   level;

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_o = level & ~hist_q;

  // Shift the asynchronous RO level through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  // History follows the synced level only while armed or running; the ARM
  // load makes a level that is already high look old, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else if (load_i || track_i) begin
      hist_q <= level;
    end
  end

endmodule

// File: rtl/ro_race_counter.sv
// N-channel ring-oscillator race counter: counts synced RO edges until a
// channel reaches the threshold or the run times out, then reports results.
module ro_race_counter
  import ro_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TMO_W       = DEF_TMO_W
) (
  input logic               clk,
  input logic               rst_n,
  ro_race_counter_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_CH);

  state_t           state_q;
  logic [CNT_W-1:0] thr_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             busy_q;
  logic             done_q;
  logic             rv_q;
  logic [IDX_W-1:0] winner_q;
  logic             tie_q;
  logic             to_q;
  logic             to_pend_q;

  logic [NUM_CH-1:0] rise;
  logic              end_thr;
  logic              end_tmo;
  logic [CNT_W-1:0]  max_v;
  logic [IDX_W-1:0]  win_d;
  logic              tie_d;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.ro_in[g]),
        .load_i  (state_q == S_ARM),
        .track_i (state_q == S_RUN),
        .rise_o  (rise[g])
      );
      assign bus.counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end
  endgenerate

  assign end_tmo = (tmo_q != '0) && (run_cnt_q == tmo_q);

  // Threshold detection plus max reduction; ascending scan with strict '>'
  // keeps the lowest index among equal maxima.
  always_comb begin
    end_thr = 1'b0;
    max_v   = cnt_q[0];
    win_d   = '0;
    tie_d   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_q[i] >= thr_q) end_thr = 1'b1;
    end
    for (int i = 1; i < NUM_CH; i++) begin
      if (cnt_q[i] > max_v) begin
        max_v = cnt_q[i];
        win_d = IDX_W'(i);
        tie_d = 1'b0;
      end else if (cnt_q[i] == max_v) begin
        tie_d = 1'b1;
      end
    end
  end

  // Run-control FSM with the edge counters and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      thr_q     <= '0;
      tmo_q     <= '0;
      run_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      to_q      <= 1'b0;
      to_pend_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            thr_q   <= bus.threshold;
            tmo_q   <= bus.timeout;
            rv_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          run_cnt_q <= '0;
          for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + 1'b1;
          if (end_thr || end_tmo) begin
            to_pend_q <= end_tmo & ~end_thr;
            state_q   <= S_FIN;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (rise[i] && (cnt_q[i] < thr_q)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
        end
        S_FIN: begin
          winner_q <= win_d;
          tie_q    <= tie_d;
          to_q     <= to_pend_q;
          done_q   <= 1'b1;
          rv_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.winner       = winner_q;
  assign bus.tie          = tie_q;
  assign bus.timed_out    = to_q;

endmodule

// File: tb/tb_ro_race_counter.sv
// Bench for ro_race_counter: periodic RO waveforms with random phases,
// reference model built from edge-arrival times and the run stop rules.
module tb_ro_race_counter;
  import ro_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int TW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ro_race_counter_if #(.NUM_CH(NCH), .CNT_W(CW), .TMO_W(TW)) bus ();

  ro_race_counter #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .TMO_W       (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode [NCH];   // 0 low, 1 high, 2 periodic
  int per  [NCH];
  int ph   [NCH];
  int exp_cnt [NCH];
  int exp_done_edge;
  int exp_to;
  int exp_win;
  int exp_tie;
  int acc_edge;
  int done_edge;
  int done_pulses;
  int pre;

  // RO level sampled at posedge number n.
  function automatic bit lvl(input int ch, input int n);
    if (mode[ch] == 0) return 1'b0;
    if (mode[ch] == 1) return 1'b1;
    return ((n + ph[ch]) % per[ch]) < (per[ch] / 2);
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) bus.ro_in[ch] = lvl(ch, cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    if (bus.done === 1'b1) begin
      done_pulses++;
      if (done_edge < 0) done_edge = cyc;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A rise first sampled at edge p is counted at edge p+SS when that edge is
  // a run edge (run edges start 2 edges after the accept edge A). Run edge r
  // stops the race if a count already reached thr, or r equals the timeout.
  task automatic model(input int a, input int thr, input int tmo);
    int c, mx, nmax;
    bit et, eo;
    for (int ch = 0; ch < NCH; ch++) exp_cnt[ch] = 0;
    exp_done_edge = -2;
    exp_to = 0;
    for (int r = 0; r < 20000; r++) begin
      c = a + 2 + r;
      et = 1'b0;
      for (int ch = 0; ch < NCH; ch++) if (exp_cnt[ch] >= thr) et = 1'b1;
      eo = (tmo != 0) && (r == tmo);
      if (et || eo) begin
        exp_to = (eo && !et) ? 1 : 0;
        exp_done_edge = c + 1;
        break;
      end
      for (int ch = 0; ch < NCH; ch++)
        if (lvl(ch, c - SS) && !lvl(ch, c - SS - 1) && exp_cnt[ch] < thr)
          exp_cnt[ch]++;
    end
    mx = 0;
    for (int ch = 0; ch < NCH; ch++) if (exp_cnt[ch] > mx) mx = exp_cnt[ch];
    exp_win = -1;
    nmax = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (exp_cnt[ch] == mx) begin
        nmax++;
        if (exp_win < 0) exp_win = ch;
      end
    end
    exp_tie = (nmax > 1) ? 1 : 0;
  endtask

  function automatic logic [NCH*CW-1:0] packed_exp();
    logic [NCH*CW-1:0] p;
    for (int ch = 0; ch < NCH; ch++) p[ch*CW +: CW] = CW'(exp_cnt[ch]);
    return p;
  endfunction

  task automatic run_and_check(input string tag, input int thr, input int tmo,
                               input int extra_start);
    bus.threshold = CW'(thr);
    bus.timeout   = TW'(tmo);
    bus.start     = 1'b1;
    done_edge     = -1;
    done_pulses   = 0;
    tick();
    bus.start = 1'b0;
    acc_edge  = cyc;
    model(acc_edge, thr, tmo);
    chk({tag, ".busy_run"}, 64'(bus.busy), 64'd1);
    chk({tag, ".rv_clr"}, 64'(bus.result_valid), 64'd0);
    for (int i = 0; i < 2000 && done_edge < 0; i++) begin
      bus.start = (i == extra_start);
      tick();
    end
    bus.start = 1'b0;
    chk({tag, ".done_edge"}, 64'(done_edge), 64'(exp_done_edge));
    chk({tag, ".counts"}, 64'(bus.counts), 64'(packed_exp()));
    chk({tag, ".winner"}, 64'(bus.winner), 64'(exp_win));
    chk({tag, ".tie"}, 64'(bus.tie), 64'(exp_tie));
    chk({tag, ".timed_out"}, 64'(bus.timed_out), 64'(exp_to));
    chk({tag, ".rv"}, 64'(bus.result_valid), 64'd1);
    chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    chk({tag, ".one_done"}, 64'(done_pulses), 64'd1);
    chk({tag, ".frozen"}, 64'(bus.counts), 64'(packed_exp()));
    chk({tag, ".rv_hold"}, 64'(bus.result_valid), 64'd1);
  endtask

  task automatic set_ch(input int ch, input int m, input int p, input int phase);
    mode[ch] = m;
    per[ch]  = p;
    ph[ch]   = phase;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.threshold = '0;
    bus.timeout   = '0;
    bus.ro_in     = '0;
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 0, 4, 0);
    done_edge = -1;
    done_pulses = 0;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.rv", 64'(bus.result_valid), 64'd0);
    chk("rst.counts", 64'(bus.counts), 64'd0);
    chk("rst.winner", 64'(bus.winner), 64'd0);
    chk("rst.tie", 64'(bus.tie), 64'd0);
    chk("rst.timed_out", 64'(bus.timed_out), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Two racing channels, no timeout
    set_ch(0, 2, 6, $urandom_range(0, 5));
    set_ch(1, 2, 10, $urandom_range(0, 9));
    for (int i = 0; i < 6; i++) tick();
    run_and_check("t1", 8, 0, -1);

    // Four channels, ch2 fastest
    set_ch(0, 2, 8, $urandom_range(0, 7));
    set_ch(1, 2, 10, $urandom_range(0, 9));
    set_ch(2, 2, 4, $urandom_range(0, 3));
    set_ch(3, 2, 12, $urandom_range(0, 11));
    for (int i = 0; i < 6; i++) tick();
    run_and_check("t2", 5, 0, -1);
    chk("t2.win2", 64'(bus.winner), 64'd2);

    // Timeout with two identical channels
    pre = $urandom_range(0, 6);
    set_ch(0, 2, 7, pre);
    set_ch(1, 2, 7, pre);
    set_ch(2, 0, 4, 0);
    set_ch(3, 0, 4, 0);
    for (int i = 0; i < 6; i++) tick();
    run_and_check("t3", 200, 50, -1);

    // Inputs held high before start, never toggling
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1, 4, 0);
    for (int i = 0; i < 6; i++) tick();
    run_and_check("t4", 200, 20, -1);
    chk("t4.zero", 64'(bus.counts), 64'd0);

    // Start pulsed again during the run
    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 0, 4, 0);
    set_ch(0, 2, 6, $urandom_range(0, 5));
    set_ch(3, 2, 8, $urandom_range(0, 7));
    for (int i = 0; i < 6; i++) tick();
    run_and_check("t5", 10, 0, 5);

    // Reset in the middle of a run, then a fresh run
    bus.threshold = CW'(200);
    bus.timeout   = '0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t6.busy", 64'(bus.busy), 64'd0);
    chk("t6.counts", 64'(bus.counts), 64'd0);
    chk("t6.rv", 64'(bus.result_valid), 64'd0);
    done_pulses = 0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("t6.no_done", 64'(done_pulses), 64'd0);
    run_and_check("t6b", 6, 0, -1);

    // Threshold zero
    run_and_check("t7", 0, 0, -1);
    chk("t7.lat", 64'(done_edge - acc_edge), 64'd3);

    // Threshold and timeout on the same run edge
    set_ch(1, 2, 5, $urandom_range(0, 4));
    for (int i = 0; i < 6; i++) tick();
    model(cyc + 1, 7, 0);
    pre = exp_done_edge - (cyc + 1) - 3;
    run_and_check("t8", 7, pre, -1);

    // Random races
    for (int k = 0; k < 5; k++) begin
      for (int ch = 0; ch < NCH; ch++)
        set_ch(ch, ($urandom_range(0, 4) == 0) ? 0 : 2,
               $urandom_range(4, 16), $urandom_range(0, 15));
      set_ch(0, 2, $urandom_range(4, 16), $urandom_range(0, 15));
      for (int i = 0; i < 6; i++) tick();
      run_and_check($sformatf("rnd%0d", k), $urandom_range(1, 20),
                    ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(10, 80), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
